// File: rtl/hermes_input_buffer_pkg.sv
// ============================================================================
// Module      : HermesPkg
// Description : Shared Hermes router types: port enum, input-buffer FSM
//               states and header flit field positions.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package HermesPkg;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } hermes_port_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HEADER  = 3'd2,
        SIZE    = 3'd3,
        PAYLOAD = 3'd4
    } hermes_buf_state_t;

    // Target router address in the header flit: X in [15:8], Y in [7:0].
    localparam int c_HDR_Y_LSB  = 0;
    localparam int c_HDR_X_LSB  = 8;
    localparam int c_HDR_ADDR_W = 8;

endpackage

`default_nettype wire

// File: rtl/hermes_flit_fifo.sv
// ============================================================================
// Module      : hermes_flit_fifo
// Description : Circular flit FIFO with wrap-bit pointers; head flit is read
//               directly from registered memory (no fall-through).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hermes_flit_fifo #(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [FLIT_SIZE-1:0] i_data,
    output logic [FLIT_SIZE-1:0] o_data,
    output logic                 o_empty,
    output logic                 o_full
);

    localparam int c_AW = $clog2(BUFFER_SIZE);

    logic [FLIT_SIZE-1:0] r_mem [BUFFER_SIZE];
    logic [c_AW:0]        r_head;
    logic [c_AW:0]        r_tail;
    logic                 w_push;
    logic                 w_pop;

    assign o_empty = (r_head == r_tail);
    assign o_full  = (r_head[c_AW-1:0] == r_tail[c_AW-1:0]) &&
                     (r_head[c_AW] != r_tail[c_AW]);

    // A write into a full FIFO is dropped rather than overwriting the head.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    generate
        for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_mem
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_mem[i] <= '0;
                end else if (w_push && (r_tail[c_AW-1:0] == c_AW'(i))) begin
                    r_mem[i] <= i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

    assign o_data = r_mem[r_head[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/hermes_input_buffer.sv
// ============================================================================
// Module      : hermes_input_buffer
// Description : Hermes per-port input buffer: flit FIFO, credit return,
//               routing request and packet streaming FSM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hermes_input_buffer
    import HermesPkg::*;
#(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 req_o,
    input  logic                 ack_h_i,
    output logic                 data_av_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 data_ack_i,
    output logic                 sending_o
);

    hermes_buf_state_t    r_state;
    hermes_buf_state_t    w_state_next;
    logic [FLIT_SIZE-1:0] r_count;
    logic                 r_sending;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;

    hermes_flit_fifo #(
        .FLIT_SIZE   (FLIT_SIZE),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (rx_i),
        .i_pop   (w_pop),
        .i_data  (data_i),
        .o_data  (data_o),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign credit_o = !w_full;
    assign w_pop    = data_av_o && data_ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (!w_empty) w_state_next = REQ;
            REQ:     if (ack_h_i)  w_state_next = HEADER;
            HEADER:  if (w_pop)    w_state_next = SIZE;
            SIZE: begin
                if (w_pop) begin
                    w_state_next = (data_o == '0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_pop && (r_count == FLIT_SIZE'(1))) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_o     = 1'b0;
        data_av_o = 1'b0;
        unique case (r_state)
            REQ:                    req_o     = 1'b1;
            HEADER, SIZE, PAYLOAD:  data_av_o = !w_empty;
            default: begin
                req_o     = 1'b0;
                data_av_o = 1'b0;
            end
        endcase
    end

    // sending_o covers exactly the streaming states, so it rises with the
    // grant and falls on the edge after the final pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count   <= '0;
            r_sending <= 1'b0;
        end else begin
            r_sending <= (w_state_next == HEADER) || (w_state_next == SIZE) ||
                         (w_state_next == PAYLOAD);
            if (w_pop && (r_state == SIZE)) begin
                r_count <= data_o;
            end else if (w_pop && (r_state == PAYLOAD) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign sending_o = r_sending;

endmodule

`default_nettype wire

// File: tb/tb_hermes_input_buffer.sv
// ============================================================================
// Module      : tb_hermes_input_buffer
// Description : Self-checking bench for hermes_input_buffer against a
//               packet-level queue model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hermes_input_buffer;

    localparam int FLIT_SIZE   = 32;
    localparam int BUFFER_SIZE = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 rx_i = 1'b0;
    logic [FLIT_SIZE-1:0] data_i = '0;
    logic                 credit_o;
    logic                 req_o;
    logic                 ack_h_i = 1'b0;
    logic                 data_av_o;
    logic [FLIT_SIZE-1:0] data_o;
    logic                 data_ack_i = 1'b0;
    logic                 sending_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: flits held in the buffer, packet phase (0 idle, 1 requesting,
    // 2 forwarding), flit index inside the packet, payload flits left.
    logic [31:0] q[$];
    logic [31:0] popped[$];
    logic [31:0] src[$];
    int          m_phase = 0;
    int          m_idx   = 0;
    logic [31:0] m_left  = 0;

    hermes_input_buffer #(
        .FLIT_SIZE   (FLIT_SIZE),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_i       (rx_i),
        .data_i     (data_i),
        .credit_o   (credit_o),
        .req_o      (req_o),
        .ack_h_i    (ack_h_i),
        .data_av_o  (data_av_o),
        .data_o     (data_o),
        .data_ack_i (data_ack_i),
        .sending_o  (sending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic exp_av;
        exp_av = (m_phase == 2) && (q.size() > 0);
        check("credit", 32'(credit_o), 32'(q.size() < BUFFER_SIZE));
        check("req", 32'(req_o), 32'(m_phase == 1));
        check("data_av", 32'(data_av_o), 32'(exp_av));
        check("sending", 32'(sending_o), 32'(m_phase == 2));
        if (exp_av) check("data", data_o, q[0]);
    endtask

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_idx   = 0;
        m_left  = 0;
    endtask

    task automatic model_edge(input bit rx, input logic [31:0] d, input bit ack,
                              input bit dack, output bit acc);
        bit          pop;
        logic [31:0] head;
        pop  = (m_phase == 2) && (q.size() > 0) && dack;
        head = (q.size() > 0) ? q[0] : 32'd0;
        acc  = rx && (q.size() < BUFFER_SIZE);
        case (m_phase)
            0: if (q.size() > 0) m_phase = 1;
            1: if (ack) begin m_phase = 2; m_idx = 0; end
            default: if (pop) begin
                if (m_idx == 0) begin
                    m_idx = 1;
                end else if (m_idx == 1) begin
                    if (head == 0) m_phase = 0;
                    else begin m_left = head; m_idx = 2; end
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 0;
                end
            end
        endcase
        if (pop) begin
            popped.push_back(head);
            void'(q.pop_front());
        end
        if (acc) q.push_back(d);
    endtask

    task automatic cyc(input bit rx, input logic [31:0] d, input bit ack,
                       input bit dack, output bit acc);
        rx_i = rx; data_i = d; ack_h_i = ack; data_ack_i = dack;
        @(posedge clk_i);
        model_edge(rx, d, ack, dack, acc);
        #1;
        check_outputs();
    endtask

    task automatic add_packet(input int n);
        src.push_back($urandom);
        src.push_back(32'(n));
        for (int k = 0; k < n; k++) src.push_back($urandom);
    endtask

    initial begin
        logic [31:0] pkt[5];
        logic [31:0] fill[9];
        bit          acc;
        int          rc;
        int          budget;
        bit          did_rst;

        // Reset with rx held high: nothing may be written.
        rx_i   = 1'b1;
        data_i = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check("rst_credit", 32'(credit_o), 32'd1);
            check("rst_req", 32'(req_o), 32'd0);
            check("rst_av", 32'(data_av_o), 32'd0);
            check("rst_sending", 32'(sending_o), 32'd0);
            check("rst_data", data_o, 32'd0);
        end
        rx_i   = 1'b0;
        rst_ni = 1'b1;
        model_reset();
        cyc(0, 0, 0, 0, acc);

        // Directed packet: ack two cycles after req rises, crossbar always ready.
        pkt = '{32'h0000_0102, 32'd3, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        popped.delete();
        rc = 0;
        for (int i = 0; i < 16; i++) begin
            rc = (m_phase == 1) ? rc + 1 : 0;
            cyc(i < 5, (i < 5) ? pkt[i] : 32'd0, rc == 2, 1, acc);
        end
        check("pkt_len", 32'(popped.size()), 32'd5);
        for (int i = 0; i < 5 && i < popped.size(); i++) check("pkt_flit", popped[i], pkt[i]);

        // Fill to full, drop a ninth write, then drain across the pointer wrap.
        fill = '{32'h0000_0A01, 32'd2, 32'h1111_1111, 32'h2222_2222,
                 32'h0000_0B02, 32'd0, 32'h0000_0C03, 32'd0, 32'hDEAD_BEEF};
        popped.delete();
        for (int i = 0; i < 9; i++) begin
            cyc(1, fill[i], 0, 0, acc);
            if (i == 7) check("full_credit", 32'(credit_o), 32'd0);
        end
        cyc(0, 0, 1, 0, acc);
        cyc(0, 0, 0, 1, acc);
        check("credit_back", 32'(credit_o), 32'd1);
        budget = 0;
        while ((q.size() > 0 || m_phase != 0) && budget < 60) begin
            cyc(0, 0, 1, 1, acc);
            budget++;
        end
        check("fill_drain_timeout", 32'(budget < 60), 32'd1);
        check("fill_len", 32'(popped.size()), 32'd8);
        for (int i = 0; i < 8 && i < popped.size(); i++) check("fill_order", popped[i], fill[i]);

        // Randomized traffic with upstream gaps and one asynchronous reset mid-payload.
        did_rst = 0;
        for (int i = 0; i < 1500; i++) begin
            if (src.size() < 8) add_packet($urandom_range(0, 5));
            if (!did_rst && i > 600 && m_phase == 2 && m_idx >= 2) begin
                did_rst = 1;
                #2 rst_ni = 1'b0;
                #1;
                check("arst_credit", 32'(credit_o), 32'd1);
                check("arst_req", 32'(req_o), 32'd0);
                check("arst_av", 32'(data_av_o), 32'd0);
                check("arst_sending", 32'(sending_o), 32'd0);
                check("arst_data", data_o, 32'd0);
                model_reset();
                src.delete();
                rx_i = 1'b0;
                @(posedge clk_i);
                #1;
                check_outputs();
                rst_ni = 1'b1;
            end else begin
                cyc(($urandom % 2) == 1 && src.size() > 0,
                    (src.size() > 0) ? src[0] : 32'd0,
                    ($urandom % 3) == 0, ($urandom % 4) != 0, acc);
                if (acc) void'(src.pop_front());
            end
        end
        check("arst_done", 32'(did_rst), 32'd1);

        budget = 0;
        while ((src.size() > 0 || q.size() > 0 || m_phase != 0) && budget < 3000) begin
            cyc(src.size() > 0, (src.size() > 0) ? src[0] : 32'd0, 1, 1, acc);
            if (acc) void'(src.pop_front());
            budget++;
        end
        check("final_drain_timeout", 32'(budget < 3000), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hermes_input_buffer.md
# hermes_input_buffer

Per-port input buffer of the Hermes router. It sits between a neighbour link and the switch control and crossbar. It stores incoming flits in a circular FIFO and returns credit to the upstream link. It requests routing for each packet header, and once granted it streams the whole packet (header, size, payload) to the crossbar, holding `sending_o` high while the packet is in transit.

## Interface
- `FLIT_SIZE`, 32: flit width in bits (minimum 20).
- `BUFFER_SIZE`, 8: FIFO depth in flits; power of two, minimum 4.
- `clk_i` input 1: single clock; all state on rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `rx_i` input 1: upstream flit valid; write occurs when `rx_i && credit_o`.
- `data_i` input FLIT_SIZE: upstream flit.
- `credit_o` output 1: FIFO not full (combinational from occupancy).
- `req_o` output 1: routing request to switch control; high while in state REQ.
- `ack_h_i` input 1: routing grant from switch control (one-cycle pulse).
- `data_av_o` output 1: head flit valid toward crossbar.
- `data_o` output FLIT_SIZE: FIFO head flit.
- `data_ack_i` input 1: crossbar consumed head flit; pop when `data_av_o && data_ack_i`.
- `sending_o` output 1: packet forwarding in progress (registered).

## Operation
- FIFO: head and tail pointers of `$clog2(BUFFER_SIZE)+1` bits (extra wrap bit).
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the wrap bits differ.
  - Pointers wrap modulo `BUFFER_SIZE`.
  - Memory is registered; `data_o = mem[head]`.
- Push and pop may occur in the same cycle at any occupancy except empty, where pop is impossible. There is no fall-through.
- `rx_i` while full is a protocol violation: the flit is dropped and state is unchanged.
- Packet format: flit 0 is the header (routing fields), flit 1 is size N (unsigned, full flit width), flits 2..N+1 are payload.
- FSM states are IDLE, REQ, HEADER, SIZE, PAYLOAD.
  - IDLE: `req_o=0`, `data_av_o=0`. Go to REQ when the FIFO is not empty.
  - REQ: `req_o=1`, `data_av_o=0`. On `ack_h_i`, set `sending_o` and go to HEADER. `ack_h_i` in any other state is ignored.
  - HEADER: `data_av_o = !empty`. On pop, go to SIZE.
  - SIZE: `data_av_o = !empty`. On pop, load the counter with the flit value.
    - N==0: go to IDLE and clear `sending_o`.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: `data_av_o = !empty`. Each pop decrements the counter. The pop taken with counter==1 goes to IDLE and clears `sending_o`.
- The counter is FLIT_SIZE bits wide, unsigned, and never underflows.
- An empty FIFO mid-packet stalls the FSM in place with `data_av_o=0`, `sending_o` held.
- Reset values:
  - Outputs: `credit_o=1`, `req_o=0`, `data_av_o=0`, `sending_o=0`, `data_o=0`.
  - Internal: memory zeroed, pointers 0, counter 0, state IDLE.
- Reset asserted mid-packet immediately discards buffered flits and returns all state to reset values.

## Timing
- Write latency: a flit accepted at edge k is visible on `data_o` in cycle k.
- Header into an empty idle buffer: written at edge k, FSM enters REQ at edge k+1, `req_o` high from cycle k+1.
- Grant: `ack_h_i` sampled high at edge g → HEADER and `sending_o=1` from cycle g.
- Streaming throughput is one flit per cycle while the FIFO is non-empty and `data_ack_i` stays high.
- `sending_o` falls in the cycle after the last-flit pop edge. Switch control frees the output port on that falling edge.
- `credit_o` reflects the post-edge occupancy. A simultaneous push and pop when full is impossible because no push is accepted.

## Structure
- `HermesPkg`: add `hermes_buf_state_t` (IDLE, REQ, HEADER, SIZE, PAYLOAD) alongside the existing port enum. Flit field positions stay defined in the package.
- Sub-module `hermes_flit_fifo`: circular memory and pointers, with ports push, pop, data in/out, empty, full.
- `hermes_input_buffer` contains the FSM, counter and `sending_o`.

## Test plan
- Reset: all outputs at reset values; hold `rx_i=1` during reset → no write, `credit_o=1`.
- Packet header=0x0000_0102, size=3, payload A,B,C; `ack_h_i` pulsed 2 cycles after `req_o` rises; `data_ack_i=1` → `data_o` shows hdr, 3, A, B, C on consecutive cycles; `sending_o` falls one cycle after the C pop.
- Write 8 flits with `data_ack_i=0` → `credit_o=0` after the 8th; a 9th `rx_i` is dropped; one pop → `credit_o=1` the next cycle; FIFO order preserved across pointer wrap.
- Size=0 packet → exactly 2 pops; FSM back in IDLE; a following header raises `req_o` again.
- Upstream stalls between payload flits (FIFO empties) → `data_av_o=0`, `sending_o` stays 1, counter unchanged; resumes correctly.
- `rst_ni` asserted mid-payload → outputs return to reset values asynchronously; the next packet is routed from a clean state.
